// File: rtl/arm_mem_pkg.sv
// Shared definitions for the core-side write buffer: memory FSM encoding,
// default buffer depth and the word-address width used throughout.
package arm_mem_pkg;

  localparam int DEF_DEPTH = 4;
  localparam int WADDR_W   = 30;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WR_BUSY = 2'd1,
    ST_RD_BUSY = 2'd2,
    ST_RD_DONE = 2'd3
  } mem_state_e;

  function automatic logic [WADDR_W-1:0] word_addr(input logic [31:0] adr);
    return adr[31:2];
  endfunction

endpackage

// File: rtl/wbuf_fifo.sv
// Store buffer storage: circular FIFO of {word address, data} with an
// associative lookup that returns the youngest entry matching a load address.
module wbuf_fifo import arm_mem_pkg::*; #(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_push,
  input  logic [WADDR_W-1:0] i_push_addr,
  input  logic [31:0]        i_push_data,
  input  logic               i_pop,
  input  logic [WADDR_W-1:0] i_match_addr,
  output logic               o_full,
  output logic               o_empty,
  output logic [WADDR_W-1:0] o_head_addr,
  output logic [31:0]        o_head_data,
  output logic               o_hit,
  output logic [31:0]        o_hit_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WADDR_W-1:0] r_addr [DEPTH];
  logic [31:0]        r_data [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               w_do_push;
  logic               w_do_pop;
  logic [PTR_W-1:0]   w_idx;
  logic               w_match;

  assign o_full      = (r_count == CNT_W'(DEPTH));
  assign o_empty     = (r_count == '0);
  assign w_do_push   = i_push & ~o_full;
  assign w_do_pop    = i_pop & ~o_empty;
  assign o_head_addr = r_addr[r_rd_ptr];
  assign o_head_data = r_data[r_rd_ptr];

  // Entry storage needs no reset: only entries below r_count are ever observed.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_addr[r_wr_ptr] <= i_push_addr;
      r_data[r_wr_ptr] <= i_push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Scan oldest to youngest so a later match overrides an earlier one.
  always_comb begin
    o_hit      = 1'b0;
    o_hit_data = '0;
    w_idx      = '0;
    w_match    = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx      = r_rd_ptr + PTR_W'(i);
      w_match    = (CNT_W'(i) < r_count) && (r_addr[w_idx] == i_match_addr);
      o_hit      = o_hit | w_match;
      o_hit_data = w_match ? r_data[w_idx] : o_hit_data;
    end
  end

endmodule

// File: rtl/mem_write_buffer.sv
// Write buffer between a single-issue core and a handshaked word memory:
// stores retire into the buffer, loads forward from it or stall for a read.
module mem_write_buffer import arm_mem_pkg::*; #(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  input  logic        Write_Enable,
  input  logic        Read_Enable,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  logic [1:0]         r_rst_sync;
  logic               w_rst_n;
  mem_state_e         r_state;
  logic               r_mem_req;
  logic               r_mem_we;
  logic [31:0]        r_mem_addr;
  logic [31:0]        r_mem_wdata;
  logic [31:0]        r_rd_data;
  logic               w_store;
  logic               w_load;
  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic               w_hit;
  logic [31:0]        w_hit_data;
  logic               w_rd_miss;
  logic [WADDR_W-1:0] w_head_addr;
  logic [31:0]        w_head_data;
  logic [WADDR_W-1:0] w_word;
  logic               w_unused;

  // Reset asserts immediately and releases on a clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_rst_sync <= 2'b00;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_rst_n   = r_rst_sync[1];
  assign w_word    = word_addr(DataAdr);
  assign w_unused  = ^DataAdr[1:0];
  assign w_store   = Write_Enable;
  assign w_load    = Read_Enable & ~Write_Enable;
  assign w_push    = w_store & ~w_full;
  assign w_pop     = (r_state == ST_WR_BUSY) & mem_ready;
  assign w_rd_miss = w_load & ~w_hit & (r_state != ST_RD_DONE);

  wbuf_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .rst_n        (w_rst_n),
    .i_push       (w_push),
    .i_push_addr  (w_word),
    .i_push_data  (WriteData),
    .i_pop        (w_pop),
    .i_match_addr (w_word),
    .o_full       (w_full),
    .o_empty      (w_empty),
    .o_head_addr  (w_head_addr),
    .o_head_data  (w_head_data),
    .o_hit        (w_hit),
    .o_hit_data   (w_hit_data)
  );

  // Core-facing response: forward from buffer, return captured read, or stall.
  always_comb begin
    Stall    = 1'b0;
    ReadData = '0;
    if (w_rst_n && w_store) begin
      Stall = w_full;
    end else if (w_rst_n && w_load) begin
      if (r_state == ST_RD_DONE) begin
        ReadData = r_rd_data;
      end else if (w_hit) begin
        ReadData = w_hit_data;
      end else begin
        Stall = 1'b1;
      end
    end else begin
      Stall = 1'b0;
    end
  end

  // Memory FSM; an empty buffer takes an arriving store straight to the bus.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state     <= ST_IDLE;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rd_data   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_rd_miss) begin
            r_state    <= ST_RD_BUSY;
            r_mem_req  <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_addr <= {w_word, 2'b00};
          end else if (!w_empty) begin
            r_state     <= ST_WR_BUSY;
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b1;
            r_mem_addr  <= {w_head_addr, 2'b00};
            r_mem_wdata <= w_head_data;
          end else if (w_push) begin
            r_state     <= ST_WR_BUSY;
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b1;
            r_mem_addr  <= {w_word, 2'b00};
            r_mem_wdata <= WriteData;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_WR_BUSY: begin
          if (mem_ready) begin
            r_state   <= ST_IDLE;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
          end
        end
        ST_RD_BUSY: begin
          if (mem_ready) begin
            r_state   <= ST_RD_DONE;
            r_mem_req <= 1'b0;
            r_rd_data <= mem_rdata;
          end
        end
        ST_RD_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state   <= ST_IDLE;
          r_mem_req <= 1'b0;
          r_mem_we  <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_write_buffer.sv
// Scoreboard bench for mem_write_buffer: a program-order memory image predicts
// load data, a queue of accepted stores predicts the memory write stream.
module tb_mem_write_buffer;

  logic        clk;
  logic        reset;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic        Write_Enable;
  logic        Read_Enable;
  logic [31:0] ReadData;
  logic        Stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  logic rand_mode;
  logic rand_ready;
  logic ready_force;
  assign mem_ready = rand_mode ? rand_ready : ready_force;

  int compared;
  int mismatched;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_wq[$];
  logic [31:0] exp_lq[$];
  logic [31:0] golden [logic [29:0]];
  logic [31:0] phys   [logic [29:0]];

  mem_write_buffer #(.DEPTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .DataAdr      (DataAdr),
    .WriteData    (WriteData),
    .Write_Enable (Write_Enable),
    .Read_Enable  (Read_Enable),
    .ReadData     (ReadData),
    .Stall        (Stall),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_ready    (mem_ready),
    .mem_rdata    (mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] init_val(input logic [29:0] w);
    return {w[15:0], ~w[15:0]};
  endfunction

  function automatic logic [31:0] gold_val(input logic [29:0] w);
    if (golden.exists(w)) return golden[w];
    return init_val(w);
  endfunction

  function automatic logic [31:0] phys_val(input logic [29:0] w);
    if (phys.exists(w)) return phys[w];
    return init_val(w);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input logic [31:0] act);
    compared++;
    mismatched++;
    $display("FAIL %s: got %h with no expectation outstanding", name, act);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Memory model behind the DUT is what survives a reset; buffered stores vanish.
  task automatic purge_model();
    exp_wq.delete();
    exp_lq.delete();
    golden.delete();
    foreach (phys[k]) golden[k] = phys[k];
  endtask

  task automatic core_op(input logic we, input logic both, input logic [31:0] adr,
                         input logic [31:0] wd, output int stalls);
    logic st;
    int   n;
    DataAdr      = adr;
    WriteData    = wd;
    Write_Enable = we;
    Read_Enable  = (!we) | both;
    if (we) begin
      golden[adr[31:2]] = wd;
      exp_wq.push_back('{addr: {adr[31:2], 2'b00}, data: wd});
    end else begin
      exp_lq.push_back(gold_val(adr[31:2]));
    end
    stalls = 0;
    n      = 0;
    st     = 1'b1;
    while (st && n < 400) begin
      @(negedge clk);
      st = Stall;
      @(posedge clk);
      #1;
      n++;
      if (st) stalls++;
    end
    if (st) flag("core_timeout", adr);
    Write_Enable = 1'b0;
    Read_Enable  = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_wq.size() != 0 || mem_req) && n < 500) begin
      step(1);
      n++;
    end
    check("drain_empty", 32'(exp_wq.size()), 32'd0);
  endtask

  initial begin
    rand_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      rand_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: compares every memory write and every completed load as it appears.
  initial begin
    wr_t         w;
    logic        p_req;
    logic        p_rdy;
    logic        p_we;
    logic [31:0] p_addr;
    logic [31:0] p_wdata;
    p_req     = 1'b0;
    p_rdy     = 1'b0;
    p_we      = 1'b0;
    p_addr    = '0;
    p_wdata   = '0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (mem_req && mem_we && mem_ready) begin
          if (exp_wq.size() == 0) begin
            flag("write_unexpected", mem_addr);
          end else begin
            w = exp_wq.pop_front();
            check("wr_addr", mem_addr, w.addr);
            check("wr_data", mem_wdata, w.data);
          end
          phys[mem_addr[31:2]] = mem_wdata;
        end
        if (Read_Enable && !Write_Enable && !Stall) begin
          if (exp_lq.size() == 0) flag("load_unexpected", ReadData);
          else check("load_data", ReadData, exp_lq.pop_front());
        end
        if (!Read_Enable && !Write_Enable) check("rdata_idle_zero", ReadData, 32'h0);
        if (p_req && !p_rdy && mem_req) begin
          check("hold_addr", mem_addr, p_addr);
          check("hold_we", 32'(mem_we), 32'(p_we));
          if (p_we) check("hold_wdata", mem_wdata, p_wdata);
        end
        if (mem_req) check("addr_align", 32'(mem_addr[1:0]), 32'h0);
        p_req     = mem_req;
        p_rdy     = mem_ready;
        p_we      = mem_we;
        p_addr    = mem_addr;
        p_wdata   = mem_wdata;
        mem_rdata = phys_val(mem_addr[31:2]);
      end else begin
        p_req = 1'b0;
      end
    end
  end

  initial begin
    int          st;
    logic        we;
    logic        both;
    int          op;
    logic [31:0] adr;

    reset        = 1'b1;
    DataAdr      = 32'h0000_0300;
    WriteData    = '0;
    Write_Enable = 1'b0;
    Read_Enable  = 1'b1;
    rand_mode    = 1'b0;
    ready_force  = 1'b0;
    #1 reset = 1'b0;
    @(posedge clk);
    #2;
    check("rst_mem_req", 32'(mem_req), 32'h0);
    check("rst_stall", 32'(Stall), 32'h0);
    check("rst_rdata", ReadData, 32'h0);
    Read_Enable = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    step(3);

    // Single store goes to the bus on the following cycle.
    ready_force = 1'b1;
    core_op(1'b1, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, st);
    check("t034_stall", 32'(st), 32'd0);
    @(negedge clk);
    check("t034_req", 32'(mem_req), 32'h1);
    check("t034_we", 32'(mem_we), 32'h1);
    check("t034_addr", mem_addr, 32'h0000_0100);
    check("t034_wdata", mem_wdata, 32'hDEAD_BEEF);
    step(1);
    wait_drain();

    // Forwarding of the youngest store to the same word.
    ready_force = 1'b0;
    core_op(1'b1, 1'b0, 32'h0000_0200, 32'h1, st);
    core_op(1'b1, 1'b0, 32'h0000_0200, 32'h2, st);
    core_op(1'b0, 1'b0, 32'h0000_0203, 32'h0, st);
    check("t036_stall", 32'(st), 32'd0);
    ready_force = 1'b1;
    wait_drain();

    // Read miss from an empty buffer with a zero-wait memory.
    phys[30'h0C0]   = 32'hCAFE_0001;
    golden[30'h0C0] = 32'hCAFE_0001;
    core_op(1'b0, 1'b0, 32'h0000_0300, 32'h0, st);
    check("t037_stall", 32'(st), 32'd2);

    // Fill to DEPTH with memory stalled; the fifth store waits for a drain.
    ready_force = 1'b0;
    for (int i = 0; i < 4; i++) begin
      core_op(1'b1, 1'b0, 32'h0000_0800 + 32'(4 * i), 32'h3500_0000 + 32'(i), st);
      check("t035_nostall", 32'(st), 32'd0);
    end
    fork
      begin
        repeat (6) @(posedge clk);
        #1 ready_force = 1'b1;
      end
      core_op(1'b1, 1'b0, 32'h0000_0810, 32'h3500_0004, st);
    join
    check("t035_full_stall", 32'(st), 32'd7);
    wait_drain();

    // Read miss behind a write that waits three cycles for memory.
    ready_force = 1'b0;
    core_op(1'b1, 1'b0, 32'h0000_0400, 32'h3838_3838, st);
    fork
      begin
        repeat (3) @(posedge clk);
        #1 ready_force = 1'b1;
      end
      core_op(1'b0, 1'b0, 32'h0000_0500, 32'h0, st);
    join
    check("t038_stall", 32'(st), 32'd6);
    wait_drain();

    // Reset while a read is outstanding with two stores still buffered.
    ready_force = 1'b0;
    core_op(1'b1, 1'b0, 32'h0000_0600, 32'h6000_0000, st);
    core_op(1'b1, 1'b0, 32'h0000_0604, 32'h6000_0001, st);
    core_op(1'b1, 1'b0, 32'h0000_0608, 32'h6000_0002, st);
    DataAdr      = 32'h0000_0700;
    Read_Enable  = 1'b1;
    Write_Enable = 1'b0;
    ready_force  = 1'b1;
    step(1);
    ready_force = 1'b0;
    step(1);
    @(negedge clk);
    check("t039_rd_req", 32'(mem_req), 32'h1);
    check("t039_rd_we", 32'(mem_we), 32'h0);
    check("t039_rd_addr", mem_addr, 32'h0000_0700);
    check("t039_rd_stall", 32'(Stall), 32'h1);
    #1 reset = 1'b0;
    purge_model();
    #1;
    check("t039_req_off", 32'(mem_req), 32'h0);
    check("t039_stall_off", 32'(Stall), 32'h0);
    check("t039_rdata_off", ReadData, 32'h0);
    Read_Enable = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    step(3);
    ready_force = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t039_no_write", 32'(mem_req), 32'h0);
    end
    step(1);

    // Random mix of loads and stores over a small address window.
    rand_mode = 1'b1;
    for (int i = 0; i < 300; i++) begin
      op   = int'($urandom_range(0, 99));
      we   = (op < 50);
      both = (op < 5);
      adr  = 32'h0000_1000 + 32'($urandom_range(0, 7) << 2) + 32'($urandom_range(0, 3));
      core_op(we, both, adr, $urandom, st);
      if ($urandom_range(0, 3) == 0) step(int'($urandom_range(1, 3)));
    end
    wait_drain();
    step(2);
    check("loads_all_seen", 32'(exp_lq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mem_write_buffer.md
MEM_WRITE_BUFFER -- requirements
Module: mem_write_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, write-buffer entries (power of two, >=2).
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port DataAdr  input  32  core data address; bits [1:0] ignored (word access).
REQ-005 SHALL have port WriteData  input  32  core store data.
REQ-006 SHALL have port Write_Enable  input  1  core store request.
REQ-007 SHALL have port Read_Enable  input  1  core load request (MemtoReg).
REQ-008 SHALL have port ReadData  output  32  load data to core.
REQ-009 SHALL have port Stall  output  1  core must hold PC and inputs stable while high.
REQ-010 SHALL have ports mem_req/mem_we  output  1/1  memory request, write qualifier.
REQ-011 SHALL have ports mem_addr/mem_wdata  output  32/32  memory word address (bits [1:0]=0), write data.
REQ-012 SHALL have ports mem_ready/mem_rdata  input  1/32  transfer accept; read data valid when mem_ready high on a read.

Function
REQ-013 Store with buffer not full SHALL enqueue {DataAdr[31:2], WriteData} at clock edge, Stall=0, zero core latency.
REQ-014 Store with count==DEPTH SHALL assert Stall; enqueue occurs on first edge where count<DEPTH at cycle start (no same-cycle enqueue/dequeue credit when full).
REQ-015 Load whose DataAdr[31:2] matches any valid entry SHALL return WriteData of the youngest matching entry combinationally, Stall=0.
REQ-016 Load with no match SHALL assert Stall until data returns via memory read (read miss).
REQ-017 Memory FSM states SHALL be IDLE, WR_BUSY, RD_BUSY, RD_DONE.
REQ-018 IDLE: pending read miss -> RD_BUSY (read priority over drain); else count>0 -> WR_BUSY with oldest entry; else stay.
REQ-019 WR_BUSY: mem_req=1, mem_we=1, addr/data of oldest entry held stable; on mem_ready dequeue, -> IDLE.
REQ-020 RD_BUSY: mem_req=1, mem_we=0, mem_addr={DataAdr[31:2],2'b00}; on mem_ready capture mem_rdata, -> RD_DONE.
REQ-021 RD_DONE: ReadData=captured data, Stall=0 for exactly one cycle, -> IDLE.
REQ-022 Read miss with zero-wait memory from IDLE SHALL stall exactly 2 cycles (Stall high N, N+1; data at N+2).
REQ-023 Read miss arriving during WR_BUSY SHALL wait for write completion; never abort an issued transfer.
REQ-024 mem_req SHALL be 0 in IDLE and RD_DONE; mem_addr/mem_wdata SHALL not change while mem_req=1 and mem_ready=0.
REQ-025 Read_Enable and Write_Enable both high is illegal; store SHALL take priority, load ignored.
REQ-026 Pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH and never overflow or underflow.
REQ-027 Store and drain dequeue in same cycle with count<DEPTH SHALL leave count unchanged.
REQ-028 ReadData SHALL be 0 when Read_Enable=0.

Reset
REQ-029 reset low SHALL immediately force state IDLE, count/pointers 0, captured data 0, mem_req 0, Stall 0, ReadData 0.
REQ-030 Reset mid-transfer SHALL drop the transfer and discard all buffered stores.
REQ-031 Release SHALL be synchronised so first active edge after deassertion is a normal IDLE cycle.

Structure
REQ-032 Shared package arm_mem_pkg SHALL hold FSM state encoding, default DEPTH, word-address width (30).
REQ-033 FIFO storage, pointers, count and address-match logic SHALL be sub-module wbuf_fifo; FSM and muxing stay in top.

Verification
REQ-034 Reset, store 0x100<-0xDEADBEEF, mem_ready=1 -> Stall 0; next cycle mem_req=1, mem_we=1, mem_addr=0x100, mem_wdata=0xDEADBEEF.
REQ-035 mem_ready=0, five back-to-back stores (DEPTH=4) -> Stall high on fifth until first drain completes; memory sees all five in order.
REQ-036 Stores 0x200<-1 then 0x200<-2 held in buffer, load 0x203 -> ReadData=2, Stall 0 same cycle.
REQ-037 Empty buffer, load 0x300, mem_ready=1, mem_rdata=0xCAFE0001 -> Stall high 2 cycles, ReadData=0xCAFE0001 third cycle.
REQ-038 Load miss while write to 0x400 awaits mem_ready (3 wait cycles) -> write completes first, then read issued; Stall held throughout.
REQ-039 reset low during RD_BUSY with 2 entries buffered -> mem_req 0 and Stall 0 immediately; after release no writes issued.
